// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg: key codes, drive directions and FSM state encoding for the keypad command decoder.
package key_cmd_pkg;
  localparam logic [4:0] KEY_NONE  = 5'd31;
  localparam logic [3:0] KEY_FWD   = 4'd10;
  localparam logic [3:0] KEY_BACK  = 4'd11;
  localparam logic [3:0] KEY_LEFT  = 4'd12;
  localparam logic [3:0] KEY_RIGHT = 4'd13;
  localparam logic [3:0] KEY_STOP  = 4'd14;
  localparam logic [3:0] KEY_ENTER = 4'd15;
  typedef logic [2:0] dir_t;
  localparam dir_t DIR_STOP  = 3'd0;
  localparam dir_t DIR_FWD   = 3'd1;
  localparam dir_t DIR_BACK  = 3'd2;
  localparam dir_t DIR_LEFT  = 3'd3;
  localparam dir_t DIR_RIGHT = 3'd4;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ENTRY = 1'b1;
  function automatic dir_t dir_of(input logic [3:0] c);
    return (c == KEY_FWD) ? DIR_FWD : (c == KEY_BACK) ? DIR_BACK :
           (c == KEY_LEFT) ? DIR_LEFT : (c == KEY_RIGHT) ? DIR_RIGHT : DIR_STOP;
  endfunction
endpackage

// File: rtl/key_press_detect.sv
// key_press_detect: debounces scanner codes into one registered press pulse per key press.
module key_press_detect
  import key_cmd_pkg::*;
#(
  parameter int STABLE_CNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [4:0] key_in,
  output logic       press,
  output logic [3:0] code
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  logic [4:0] k;
  logic [4:0] last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic released;
  // run length saturates so a held key never wraps back into acceptance
  always_comb begin
    k = (key_in > 5'd15) ? KEY_NONE : key_in;
    cnt_nxt = (k == KEY_NONE) ? '0 : (k != last) ? CW'(1) :
              (cnt == CW'(STABLE_CNT)) ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      last <= KEY_NONE;
      cnt <= '0;
      released <= 1'b0;
      press <= 1'b0;
      code <= '0;
    end else begin
      press <= 1'b0;
      if (sample_en) begin
        last <= k;
        cnt <= cnt_nxt;
        if (k == KEY_NONE) released <= 1'b1;
        else if (released && cnt_nxt == CW'(STABLE_CNT)) begin
          released <= 1'b0;
          press <= 1'b1;
          code <= k[3:0];
        end
      end
    end
endmodule

// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder: turns debounced keypad presses into drive direction and two-digit speed commands.
module key_cmd_decoder
  import key_cmd_pkg::*;
#(
  parameter int STABLE_CNT    = 2,
  parameter int TIMEOUT_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [4:0] key_in,
  output logic [2:0] dir,
  output logic [6:0] speed,
  output logic       cmd_valid,
  output logic       entry_active,
  output logic [6:0] entry_val
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic press;
  logic [3:0] code;
  logic [0:0] state;
  logic two;
  logic digit;
  logic [TW-1:0] ticks;
  key_press_detect #(.STABLE_CNT(STABLE_CNT)) u_det (
    .clk(clk),
    .rst_n(rst_n),
    .sample_en(sample_en),
    .key_in(key_in),
    .press(press),
    .code(code)
  );
  assign digit = code < 4'd10;
  assign entry_active = state == ST_ENTRY;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ST_IDLE;
      dir <= DIR_STOP;
      speed <= '0;
      cmd_valid <= 1'b0;
      entry_val <= '0;
      two <= 1'b0;
      ticks <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (state == ST_IDLE) begin
        ticks <= '0;
        if (press) begin
          if (digit) begin
            state <= ST_ENTRY;
            entry_val <= {3'b000, code};
            two <= 1'b0;
          end else if (code == KEY_STOP) begin
            dir <= DIR_STOP;
            speed <= '0;
            cmd_valid <= 1'b1;
          end else if (code != KEY_ENTER) begin
            dir <= dir_of(code);
            cmd_valid <= 1'b1;
          end
        end
      end else if (press) begin
        ticks <= '0;
        if (digit) begin
          if (!two) begin
            entry_val <= entry_val * 7'd10 + {3'b000, code};
            two <= 1'b1;
          end
        end else if (code == KEY_ENTER) begin
          speed <= entry_val;
          cmd_valid <= 1'b1;
          state <= ST_IDLE;
          entry_val <= '0;
        end else if (code == KEY_STOP) begin
          state <= ST_IDLE;
          entry_val <= '0;
        end
      end else if (sample_en) begin
        if (ticks == TW'(TIMEOUT_TICKS - 1)) begin
          state <= ST_IDLE;
          entry_val <= '0;
          ticks <= '0;
        end else ticks <= ticks + 1'b1;
      end
    end
endmodule

// File: tb/tb_key_cmd_decoder.sv
// tb_key_cmd_decoder: scenario and randomized checks of the keypad decoder against a behavioural model.
module tb_key_cmd_decoder;
  localparam int STABLE = 2;
  localparam int TIMEOUT = 100;
  logic clk = 0;
  logic rst_n = 0;
  logic sample_en = 0;
  logic [4:0] key_in = 5'd31;
  logic [2:0] dir;
  logic [6:0] speed;
  logic cmd_valid;
  logic entry_active;
  logic [6:0] entry_val;
  int passed = 0;
  int total = 0;
  int n_cmd = 0;
  int n_dbl = 0;
  logic prev_cv = 0;
  int m_dir, m_speed, m_val, m_nd, m_ticks, m_cmds, m_run, m_last;
  bit m_rel, m_entry;
  key_cmd_decoder #(.STABLE_CNT(STABLE), .TIMEOUT_TICKS(TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_en(sample_en),
    .key_in(key_in),
    .dir(dir),
    .speed(speed),
    .cmd_valid(cmd_valid),
    .entry_active(entry_active),
    .entry_val(entry_val)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (cmd_valid === 1'b1) n_cmd <= n_cmd + 1;
    if (cmd_valid === 1'b1 && prev_cv === 1'b1) n_dbl <= n_dbl + 1;
    prev_cv <= cmd_valid;
  end
  task automatic m_reset();
    m_dir = 0; m_speed = 0; m_val = 0; m_nd = 0; m_ticks = 0;
    m_run = 0; m_last = 31; m_rel = 0; m_entry = 0;
  endtask
  task automatic m_step(input int k);
    int c;
    bit pr;
    c = (k > 15) ? 31 : k;
    pr = 0;
    if (c == 31) begin
      m_rel = 1; m_run = 0;
    end else begin
      m_run = (c == m_last) ? m_run + 1 : 1;
      if (m_rel && m_run == STABLE) begin m_rel = 0; pr = 1; end
    end
    m_last = c;
    if (pr) begin
      m_ticks = 0;
      if (!m_entry) begin
        if (c < 10) begin m_entry = 1; m_val = c; m_nd = 1; end
        else if (c == 14) begin m_dir = 0; m_speed = 0; m_cmds++; end
        else if (c < 14) begin m_dir = (c == 10) ? 1 : (c == 11) ? 2 : (c == 12) ? 3 : 4; m_cmds++; end
      end else if (c < 10) begin
        if (m_nd == 1) begin m_val = m_val * 10 + c; m_nd = 2; end
      end else if (c == 15) begin
        m_speed = m_val; m_cmds++; m_entry = 0; m_val = 0;
      end else if (c == 14) begin
        m_entry = 0; m_val = 0;
      end
    end else if (m_entry) begin
      m_ticks++;
      if (m_ticks == TIMEOUT) begin m_entry = 0; m_val = 0; m_ticks = 0; end
    end
  endtask
  task automatic step(input int k);
    key_in = 5'(k);
    sample_en = 1;
    @(posedge clk); #1;
    sample_en = 0;
    repeat (3) @(posedge clk);
    #1;
    m_step(k);
  endtask
  task automatic press(input int k);
    step(31); step(k); step(k);
  endtask
  task automatic do_reset();
    rst_n = 0;
    sample_en = 1;
    repeat (3) @(posedge clk);
    #1;
    sample_en = 0;
    rst_n = 1;
    m_reset();
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({dir, speed, cmd_valid, entry_active, entry_val} !== 19'd0)
      $display("FAIL reset: dir=%0d speed=%0d cv=%b act=%b val=%0d required all 0", dir, speed, cmd_valid, entry_active, entry_val);
    else passed++;
    rst_n = 1;
    m_reset();
    m_cmds = 0;
  endtask
  task automatic test_single_cmd();
    int c0;
    c0 = n_cmd;
    press(10);
    total++; if (dir !== 3'd1 || n_cmd != c0 + 1) $display("FAIL fwd_press: dir=%0d cmds=%0d required dir=1 cmds=1", dir, n_cmd - c0);
    else passed++;
    repeat (20) step(10);
    total++; if (n_cmd != c0 + 1 || dir !== 3'd1) $display("FAIL held_key: cmds=%0d dir=%0d required cmds=1 dir=1", n_cmd - c0, dir);
    else passed++;
  endtask
  task automatic test_entry();
    int c0;
    c0 = n_cmd;
    press(4);
    total++; if (entry_active !== 1'b1 || entry_val !== 7'd4) $display("FAIL first_digit: act=%b val=%0d required act=1 val=4", entry_active, entry_val);
    else passed++;
    press(2);
    total++; if (entry_val !== 7'd42) $display("FAIL second_digit: val=%0d required 42", entry_val);
    else passed++;
    press(15);
    total++; if (speed !== 7'd42 || dir !== 3'd1 || n_cmd != c0 + 1 || entry_active !== 1'b0 || entry_val !== 7'd0)
      $display("FAIL enter: speed=%0d dir=%0d cmds=%0d act=%b val=%0d required 42 1 1 0 0", speed, dir, n_cmd - c0, entry_active, entry_val);
    else passed++;
  endtask
  task automatic test_third_digit();
    press(7); press(3); press(5);
    total++; if (entry_val !== 7'd73) $display("FAIL third_digit: val=%0d required 73", entry_val);
    else passed++;
    press(15);
    total++; if (speed !== 7'd73) $display("FAIL speed_73: speed=%0d required 73", speed);
    else passed++;
  endtask
  task automatic test_timeout();
    int c0;
    c0 = n_cmd;
    press(9);
    repeat (TIMEOUT - 1) step(31);
    total++; if (entry_active !== 1'b1 || entry_val !== 7'd9) $display("FAIL before_timeout: act=%b val=%0d required act=1 val=9", entry_active, entry_val);
    else passed++;
    step(31);
    total++; if (entry_active !== 1'b0 || entry_val !== 7'd0 || n_cmd != c0 || speed !== 7'd73)
      $display("FAIL timeout: act=%b val=%0d cmds=%0d speed=%0d required 0 0 0 73", entry_active, entry_val, n_cmd - c0, speed);
    else passed++;
  endtask
  task automatic test_no_release();
    int c0;
    press(14);
    total++; if (dir !== 3'd0 || speed !== 7'd0) $display("FAIL stop_key: dir=%0d speed=%0d required 0 0", dir, speed);
    else passed++;
    c0 = n_cmd;
    press(10);
    step(11); step(11);
    total++; if (dir !== 3'd1 || n_cmd != c0 + 1) $display("FAIL valid_to_valid: dir=%0d cmds=%0d required dir=1 cmds=1", dir, n_cmd - c0);
    else passed++;
    press(11);
    total++; if (dir !== 3'd2 || n_cmd != c0 + 2) $display("FAIL after_release: dir=%0d cmds=%0d required dir=2 cmds=2", dir, n_cmd - c0);
    else passed++;
  endtask
  task automatic test_reset_held();
    int c0;
    press(5);
    c0 = n_cmd;
    do_reset();
    total++; if (entry_active !== 1'b0 || entry_val !== 7'd0 || n_cmd != c0)
      $display("FAIL reset_mid_entry: act=%b val=%0d cmds=%0d required 0 0 0", entry_active, entry_val, n_cmd - c0);
    else passed++;
    press(12);
    c0 = n_cmd;
    do_reset();
    repeat (5) step(12);
    total++; if (dir !== 3'd0 || speed !== 7'd0 || n_cmd != c0) $display("FAIL held_through_reset: dir=%0d speed=%0d cmds=%0d required 0 0 0", dir, speed, n_cmd - c0);
    else passed++;
    press(12);
    total++; if (dir !== 3'd3 || n_cmd != c0 + 1) $display("FAIL repress_after_reset: dir=%0d cmds=%0d required dir=3 cmds=1", dir, n_cmd - c0);
    else passed++;
  endtask
  task automatic test_random();
    int k, hold;
    for (int i = 0; i < 400; i++) begin
      k = ($urandom_range(0, 1) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
      hold = $urandom_range(1, 4);
      for (int j = 0; j < hold; j++) step(k);
      total++; if (dir !== 3'(m_dir) || speed !== 7'(m_speed) || entry_active !== m_entry || entry_val !== 7'(m_val) || n_cmd != m_cmds)
        $display("FAIL random[%0d]: dir=%0d speed=%0d act=%b val=%0d cmds=%0d required %0d %0d %b %0d %0d",
                 i, dir, speed, entry_active, entry_val, n_cmd, m_dir, m_speed, m_entry, m_val, m_cmds);
      else passed++;
    end
  endtask
  initial begin
    m_cmds = 0;
    test_reset();
    test_single_cmd();
    test_entry();
    test_third_digit();
    test_timeout();
    test_no_release();
    test_reset_held();
    test_random();
    total++; if (n_dbl != 0) $display("FAIL back_to_back_cmd_valid: count=%0d required 0", n_dbl);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/key_cmd_decoder.md
KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 2: consecutive identical valid samples required to accept a press.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 100: sample_en strobes without an accepted press before an entry is abandoned.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port sample_en  input  1  one-clk strobe at scan rate; key_in is sampled only when it is high.
REQ-006 SHALL have port key_in  input  5  scanner key code: 0-15 = key pressed; 31 = no key.
REQ-007 SHALL have port dir  output  3  drive command: 0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT.
REQ-008 SHALL have port speed  output  7  committed speed setpoint, 0-99.
REQ-009 SHALL have port cmd_valid  output  1  one-clk pulse when dir or speed is (re)written.
REQ-010 SHALL have port entry_active  output  1  high while state is ENTRY.
REQ-011 SHALL have port entry_val  output  7  digits accumulated so far, for display.

Function
REQ-012 SHALL treat key_in values 16-30 as 31 (no key).
REQ-013 SHALL accept a press when, on sample_en, key_in equals the same valid code for STABLE_CNT consecutive samples, and at least one no-key sample has been seen since the last accepted press or since reset.
REQ-014 SHALL issue exactly one press event per accepted press; a held key, or a valid code changing to another valid code without an intervening no-key sample, SHALL issue no further event.
REQ-015 SHALL register the press event on the sample_en edge that completes acceptance; FSM outputs SHALL update on the next clock edge (2-edge latency from the final sample).
REQ-016 SHALL implement states IDLE and ENTRY.
REQ-017 IDLE: keys 10/11/12/13 SHALL set dir to FWD/BACK/LEFT/RIGHT and pulse cmd_valid; speed unchanged.
REQ-018 IDLE: key 14 SHALL set dir=STOP, speed=0 and pulse cmd_valid.
REQ-019 IDLE: digit d (0-9) SHALL set entry_val=d, digit count=1, and go to ENTRY; key 15 SHALL be ignored.
REQ-020 ENTRY: a digit with count=1 SHALL set entry_val=entry_val*10+d and count=2; with count=2 it SHALL be ignored.
REQ-021 ENTRY: key 15 SHALL copy entry_val to speed, pulse cmd_valid, keep dir, and return to IDLE.
REQ-022 ENTRY: key 14 SHALL discard the entry and return to IDLE without cmd_valid; keys 10-13 SHALL be ignored.
REQ-023 ENTRY: a timeout counter SHALL count sample_en strobes, clear on each accepted press, and on reaching TIMEOUT_TICKS SHALL discard the entry and return to IDLE without cmd_valid.
REQ-024 entry_val SHALL read 0 whenever state is IDLE.
REQ-025 cmd_valid SHALL never be high on two consecutive clocks.

Reset
REQ-026 On rst_n low at a clock edge: dir=STOP, speed=0, cmd_valid=0, entry_active=0, entry_val=0, state=IDLE, stability and timeout counters=0, and the "released" flag SHALL be clear, so a key held through reset produces no event until released.
REQ-027 Reset asserted mid-entry SHALL discard the entry without cmd_valid.

Structure
REQ-028 A shared package key_cmd_pkg SHALL hold KEY_NONE=31, codes KEY_FWD=10, KEY_BACK=11, KEY_LEFT=12, KEY_RIGHT=13, KEY_STOP=14, KEY_ENTER=15, the dir encodings, and the state encoding.
REQ-029 Press qualification (REQ-012 to REQ-015) SHALL be a sub-module key_press_detect, outputting a one-clk press pulse and a 4-bit code.

Verification
REQ-030 After release, key_in=10 for 2 samples, then held for 20 -> one cmd_valid, dir=1; no further pulses.
REQ-031 Press 4, then 2, then 15 -> entry_active high after the first digit, entry_val 4 then 42; on 15, speed=42 with one cmd_valid, dir unchanged.
REQ-032 Press 7, 3, 5, then 15 -> third digit ignored, speed=73.
REQ-033 Press 9, then 100 idle samples -> back to IDLE, entry_val=0, no cmd_valid, speed unchanged.
REQ-034 key_in 10 directly to 11 without 31, then 31, then 11 -> only the 10 and final 11 presses produce events, giving dir 1 then 2.
REQ-035 Hold key 12 through rst_n low, then release rst_n -> no event until key_in goes to 31 and 12 is pressed again; after reset dir=0, speed=0.
